// File: rtl/shift_stream_pkg.sv
// Shared definitions for the serial word collector: FSM encoding and default
// word geometry.
package shift_stream_pkg;

  localparam int         DEFAULT_WIDTH         = 4;
  localparam logic [3:0] DEFAULT_MATCH_PATTERN = 4'b1100;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/serial_word_assembler.sv
// Reassembles an MSB-first serial bit stream into WIDTH-bit words.
// word_done is a combinational strobe valid in the cycle the last bit is accepted.
module serial_word_assembler
  import shift_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             shift_valid,
  input  logic             frame_start,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic [CNTW-1:0]  bit_count
);

  localparam logic [CNTW-1:0] LAST_COUNT = CNTW'(WIDTH - 1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [WIDTH-2:0] partial_r;
  logic [WIDTH-2:0] partial_nxt_s;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_nxt_s;
  logic [WIDTH-1:0] shifted_s;
  logic             accept_s;

  // Next-state logic for the FSM, partial word and bit counter.
  always_comb begin
    accept_s      = shift_valid & ((state_r == ST_COLLECT) | frame_start);
    shifted_s     = {partial_r, serial_in};
    state_nxt_s   = state_r;
    partial_nxt_s = partial_r;
    count_nxt_s   = count_r;
    word_done     = 1'b0;
    word          = shifted_s;
    if (accept_s) begin
      if (frame_start) begin
        // A frame marker realigns: any partial word is abandoned, even one bit short.
        state_nxt_s      = ST_COLLECT;
        partial_nxt_s    = {(WIDTH-1){1'b0}};
        partial_nxt_s[0] = serial_in;
        count_nxt_s      = CNTW'(1);
      end else if (count_r == LAST_COUNT) begin
        word_done     = 1'b1;
        partial_nxt_s = {(WIDTH-1){1'b0}};
        count_nxt_s   = {CNTW{1'b0}};
      end else begin
        partial_nxt_s = shifted_s[WIDTH-2:0];
        count_nxt_s   = count_r + CNTW'(1);
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r   <= ST_IDLE;
      partial_r <= {(WIDTH-1){1'b0}};
      count_r   <= {CNTW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      partial_r <= partial_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  assign bit_count = count_r;

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-word collector with a one-entry valid/ready output register and a
// sticky overflow flag. Optional pattern compare enabled by MATCH_DETECT_EN.
module serial_word_collector
  import shift_stream_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MATCH_PATTERN = DEFAULT_MATCH_PATTERN,
  localparam int              CNTW          = $clog2(WIDTH)
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             serialIn,
  input  logic             shiftValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] wordOut,
  output logic             wordValid,
  input  logic             wordReady,
  output logic [CNTW-1:0]  bitCount,
  output logic             overflow,
  output logic             match
);

  logic             word_done_s;
  logic [WIDTH-1:0] word_s;
  logic             load_s;
  logic [WIDTH-1:0] word_out_r;
  logic             word_valid_r;
  logic             overflow_r;

  serial_word_assembler #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_assembler (
    .clk         (clockpulse),
    .clear       (clear),
    .serial_in   (serialIn),
    .shift_valid (shiftValid),
    .frame_start (frameStart),
    .word_done   (word_done_s),
    .word        (word_s),
    .bit_count   (bitCount)
  );

  assign load_s = word_done_s & (~word_valid_r | wordReady);

  // Output register, handshake and sticky overflow.
  always_ff @(posedge clockpulse) begin
    if (clear) begin
      word_out_r   <= {WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else if (load_s) begin
      word_out_r   <= word_s;
      word_valid_r <= 1'b1;
    end else if (word_done_s) begin
      // Full and not being drained: the new word is lost.
      overflow_r   <= 1'b1;
    end else if (word_valid_r & wordReady) begin
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= word_valid_r;
    end
  end

`ifdef MATCH_DETECT_EN
  logic match_r;

  // Compare result tracks each load of the output register.
  always_ff @(posedge clockpulse) begin
    if (clear) begin
      match_r <= 1'b0;
    end else if (load_s) begin
      match_r <= (word_s == MATCH_PATTERN);
    end else begin
      match_r <= match_r;
    end
  end

  assign match = match_r;
`else
  assign match = 1'b0;
`endif

  assign wordOut   = word_out_r;
  assign wordValid = word_valid_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector (default WIDTH=4).
module tb_serial_word_collector;

  logic       clockpulse = 1'b0;
  logic       clear      = 1'b1;
  logic       serialIn   = 1'b0;
  logic       shiftValid = 1'b0;
  logic       frameStart = 1'b0;
  logic       wordReady  = 1'b0;
  logic [3:0] wordOut;
  logic       wordValid;
  logic [1:0] bitCount;
  logic       overflow;
  logic       match;

  int errors = 0;
  int checks = 0;

`ifdef MATCH_DETECT_EN
  localparam logic MATCH_ON = 1'b1;
`else
  localparam logic MATCH_ON = 1'b0;
`endif

  serial_word_collector dut (
    .clockpulse (clockpulse),
    .clear      (clear),
    .serialIn   (serialIn),
    .shiftValid (shiftValid),
    .frameStart (frameStart),
    .wordOut    (wordOut),
    .wordValid  (wordValid),
    .wordReady  (wordReady),
    .bitCount   (bitCount),
    .overflow   (overflow),
    .match      (match)
  );

  always #5 clockpulse = ~clockpulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic step(input logic clr, input logic sv, input logic fs,
                      input logic b, input logic rdy);
    clear = clr; shiftValid = sv; frameStart = fs; serialIn = b; wordReady = rdy;
    @(posedge clockpulse);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] w, input logic v,
                           input logic [1:0] c, input logic o, input logic m);
    check({tag, ".wordOut"},   {28'd0, wordOut},   {28'd0, w});
    check({tag, ".wordValid"}, {31'd0, wordValid}, {31'd0, v});
    check({tag, ".bitCount"},  {30'd0, bitCount},  {30'd0, c});
    check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, o});
    check({tag, ".match"},     {31'd0, match},     {31'd0, m});
  endtask

  initial begin
    // 1. Reset and IDLE bits without frameStart
    #2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("reset", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("idle_ignore", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    // 2. Basic word 1100
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("basic.cnt1", {30'd0, bitCount}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("basic.notyet", {31'd0, wordValid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("basic", 4'b1100, 1'b1, 2'd0, 1'b0, MATCH_ON);

    // 3. Backpressure: 1010 then 0110 back-to-back, wordReady low
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("bp.first", 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("bp.drop", 4'b1010, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("bp.consume", 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp.ready_idle", {31'd0, wordValid}, 32'd0);

    // 4. Simultaneous consume and completion; clear also drops overflow
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sim.clear_ovf", {31'd0, overflow}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("sim.held", 4'b1010, 1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_all("sim", 4'b0011, 1'b1, 2'd0, 1'b0, 1'b0);

    // 5. Realign: 1,1 then frameStart with 1,0,0,1
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("realign.cnt2", {30'd0, bitCount}, 32'd2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("realign.cnt1", {30'd0, bitCount}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("realign.nowd", {31'd0, wordValid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("realign", 4'b1001, 1'b1, 2'd0, 1'b0, 1'b0);

    // 5b. Realign at bitCount==WIDTH-1: no word completes
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all("realign3", 4'h0, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("realign3.word", 4'b1100, 1'b1, 2'd0, 1'b0, MATCH_ON);

    // 6. Clear mid-word, then unframed bits are ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("midclr.cnt3", {30'd0, bitCount}, 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_all("midclr", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    check_all("midclr.idle", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
